// File: rtl/soc_stim_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_stim_sequencer_if                                           |
// | Purpose  : Table-programming and playback-control bundle of the sequencer  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface soc_stim_sequencer_if #(
  parameter int AW      = 4,
  parameter int ENTRY_W = 54
);
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [ENTRY_W-1:0] prog_wdata;
  logic [AW:0]        num_entries;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [AW-1:0]      entry_idx;

  modport master (
    output prog_we, prog_addr, prog_wdata, num_entries, start, abort,
    input  busy, done, entry_idx
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, num_entries, start, abort,
    output busy, done, entry_idx
  );
endinterface
`default_nettype wire

// File: rtl/soc_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_stim_sequencer                                              |
// | Purpose  : Replays a table of (delay, switches, button mask, press width)   |
// |            entries onto the SoC Switches/Buttons inputs, cycle-accurately.  |
// |            Optional macro STIM_LOOP_EN adds a `loop` input for replay.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module soc_stim_sequencer #(
  parameter int              SW_W     = 16,
  parameter int              BTN_W    = 2,
  parameter int              DEPTH    = 16,
  parameter int              DLY_W    = 20,
  parameter int              PRS_W    = 16,
  parameter logic [SW_W-1:0] SW_RESET = SW_W'(1)
) (
  input  wire logic              HCLK,
  input  wire logic              HRESETn,
  soc_stim_sequencer_if.slave    ctl,
`ifdef STIM_LOOP_EN
  input  wire logic              loop,
`endif
  output logic [SW_W-1:0]        Switches,
  output logic [BTN_W-1:0]       Buttons
);

  localparam int ENTRY_W   = DLY_W + SW_W + BTN_W + PRS_W;
  localparam int AW        = $clog2(DEPTH);
  localparam int CNT_W     = (DLY_W > PRS_W) ? DLY_W : PRS_W;
  localparam int C_DLY_LSB = SW_W + BTN_W + PRS_W;
  localparam int C_SW_LSB  = BTN_W + PRS_W;
  localparam int C_BTN_LSB = PRS_W;

  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_DELAY = 2'd1;
  localparam logic [1:0] C_PRESS = 2'd2;

  logic [ENTRY_W-1:0] r_table [DEPTH];

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [AW-1:0]    r_idx,   w_idx_nxt;
  logic [AW:0]      r_n,     w_n_nxt;
  logic [SW_W-1:0]  r_sw,    w_sw_nxt;
  logic [BTN_W-1:0] r_btn,   w_btn_nxt;
  logic             r_done,  w_done_nxt;

  logic             w_wr;
  logic             w_last;
  logic             w_wrap;
  logic             w_advance;
  logic [AW:0]      w_n_clamp;
  logic [AW-1:0]    w_nidx;
  logic [DLY_W-1:0] w_dly0;
  logic [DLY_W-1:0] w_ndly;
  logic [SW_W-1:0]  w_cur_sw;
  logic [BTN_W-1:0] w_cur_mask;
  logic [PRS_W-1:0] w_cur_prs;

  // The table is frozen while playing so every entry is read as it was at start.
  assign w_wr = ctl.prog_we && (r_state == C_IDLE);

  always_ff @(posedge HCLK) begin
    if (w_wr) begin
      r_table[ctl.prog_addr] <= ctl.prog_wdata;
    end
  end

  // Write-first: a start in the same cycle as a write to entry 0 sees the new delay.
  assign w_dly0 = (w_wr && (ctl.prog_addr == '0)) ? ctl.prog_wdata[C_DLY_LSB +: DLY_W]
                                                  : r_table[0][C_DLY_LSB +: DLY_W];

  assign w_n_clamp  = (ctl.num_entries > C_DEPTH) ? C_DEPTH : ctl.num_entries;
  assign w_last     = ({1'b0, r_idx} == (r_n - (AW + 1)'(1)));
`ifdef STIM_LOOP_EN
  assign w_wrap     = w_last && loop;
`else
  assign w_wrap     = 1'b0;
`endif
  assign w_nidx     = w_wrap ? '0 : (r_idx + AW'(1));
  assign w_ndly     = r_table[w_nidx][C_DLY_LSB +: DLY_W];
  assign w_cur_sw   = r_table[r_idx][C_SW_LSB +: SW_W];
  assign w_cur_mask = r_table[r_idx][C_BTN_LSB +: BTN_W];
  assign w_cur_prs  = r_table[r_idx][PRS_W-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin : p_state
    if (!HRESETn) begin
      r_state <= C_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_n     <= '0;
      r_sw    <= SW_RESET;
      r_btn   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_n     <= w_n_nxt;
      r_sw    <= w_sw_nxt;
      r_btn   <= w_btn_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_n_nxt     = r_n;
    w_sw_nxt    = r_sw;
    w_btn_nxt   = r_btn;
    w_done_nxt  = 1'b0;
    w_advance   = 1'b0;

    case (r_state)
      C_IDLE: begin
        if (ctl.start && (ctl.num_entries != '0)) begin
          w_n_nxt     = w_n_clamp;
          w_idx_nxt   = '0;
          w_cnt_nxt   = CNT_W'(w_dly0);
          w_state_nxt = C_DELAY;
        end
      end
      C_DELAY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_sw_nxt = w_cur_sw;
          if ((w_cur_mask != '0) && (w_cur_prs != '0)) begin
            w_btn_nxt   = w_cur_mask;
            w_cnt_nxt   = CNT_W'(w_cur_prs) - CNT_W'(1);
            w_state_nxt = C_PRESS;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      C_PRESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_btn_nxt = '0;
          w_advance = 1'b1;
        end
      end
      default: w_state_nxt = C_IDLE;
    endcase

    // Advancing shares the edge with the last action of the entry, so no gap cycle.
    if (w_advance) begin
      if (w_last && !w_wrap) begin
        w_state_nxt = C_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_idx_nxt   = w_nidx;
        w_cnt_nxt   = CNT_W'(w_ndly);
        w_state_nxt = C_DELAY;
      end
    end

    // Abort overrides everything, including a same-cycle start or entry update.
    if (ctl.abort) begin
      w_state_nxt = C_IDLE;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_n_nxt     = r_n;
      w_sw_nxt    = r_sw;
      w_btn_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_comb begin : p_out
    Switches      = r_sw;
    Buttons       = r_btn;
    ctl.busy      = (r_state != C_IDLE);
    ctl.done      = r_done;
    ctl.entry_idx = r_idx;
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_soc_stim_sequencer                                           |
// | Purpose  : Directed self-checking bench for soc_stim_sequencer (one-shot)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_soc_stim_sequencer;

  localparam int AW = 4;
  localparam int EW = 54;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic [15:0] Switches;
  logic [1:0]  Buttons;

  int checks = 0;
  int errors = 0;
  int cycles;

  soc_stim_sequencer_if #(.AW(AW), .ENTRY_W(EW)) bus ();

  soc_stim_sequencer dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .ctl      (bus),
    .Switches (Switches),
    .Buttons  (Buttons)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [EW-1:0] ent(input logic [19:0] d, input logic [15:0] sw,
                                         input logic [1:0] m, input logic [15:0] p);
    return {d, sw, m, p};
  endfunction

  task automatic prog(input int a, input logic [EW-1:0] e);
    bus.prog_addr  = AW'(a);
    bus.prog_wdata = e;
    bus.prog_we    = 1'b1;
    tick();
    bus.prog_we    = 1'b0;
  endtask

  task automatic go(input int n);
    bus.num_entries = (AW + 1)'(n);
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Expected per-cycle traces for the three-entry run
  logic [15:0] t3_sw   [10] = '{16'h3, 16'h10, 16'h10, 16'h10, 16'h20, 16'h20, 16'h20, 16'h30, 16'h30, 16'h30};
  logic [1:0]  t3_btn  [10] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [3:0]  t3_idx  [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
  logic        t3_done [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        t3_busy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_wdata  = '0;
    bus.num_entries = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;

    // Reset values
    #12;
    check("rst sw",   Switches, 16'h0001);
    check("rst btn",  Buttons, 2'b00);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst idx",  bus.entry_idx, 4'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    tick();

    // Single entry: delay 4, press 3
    prog(0, ent(20'd4, 16'h0003, 2'b01, 16'd3));
    go(1);
    check("t2 busy at start", bus.busy, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t2 sw k%0d", k),   Switches, (k >= 5) ? 16'h0003 : 16'h0001);
      check($sformatf("t2 btn k%0d", k),  Buttons, (k >= 5 && k <= 7) ? 2'b01 : 2'b00);
      check($sformatf("t2 done k%0d", k), bus.done, (k == 8) ? 1'b1 : 1'b0);
      check($sformatf("t2 busy k%0d", k), bus.busy, (k < 8) ? 1'b1 : 1'b0);
    end

    // Three entries, middle one without buttons
    prog(0, ent(20'd1, 16'h0010, 2'b10, 16'd2));
    prog(1, ent(20'd0, 16'h0020, 2'b00, 16'd5));
    prog(2, ent(20'd2, 16'h0030, 2'b11, 16'd1));
    go(3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t3 sw k%0d", k),   Switches, t3_sw[k-1]);
      check($sformatf("t3 btn k%0d", k),  Buttons, t3_btn[k-1]);
      check($sformatf("t3 idx k%0d", k),  bus.entry_idx, t3_idx[k-1]);
      check($sformatf("t3 done k%0d", k), bus.done, t3_done[k-1]);
      check($sformatf("t3 busy k%0d", k), bus.busy, t3_busy[k-1]);
    end

    // Abort during the press of entry 1, then restart from entry 0
    prog(1, ent(20'd0, 16'h0020, 2'b01, 16'd4));
    go(2);
    for (int k = 1; k <= 6; k++) tick();
    check("t4 btn before abort", Buttons, 2'b01);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4 btn after abort",  Buttons, 2'b00);
    check("t4 busy after abort", bus.busy, 1'b0);
    check("t4 done after abort", bus.done, 1'b0);
    check("t4 sw hold",          Switches, 16'h0020);
    check("t4 idx hold",         bus.entry_idx, 4'd1);
    tick();
    check("t4 no late done", bus.done, 1'b0);
    go(2);
    check("t4 restart idx",  bus.entry_idx, 4'd0);
    check("t4 restart busy", bus.busy, 1'b1);
    tick();
    tick();
    check("t4 restart sw",  Switches, 16'h0010);
    check("t4 restart btn", Buttons, 2'b10);
    wait_done(20, cycles);
    check("t4 done latency", cycles, 7);
    check("t4 final sw", Switches, 16'h0020);

    // Ignored requests: abort in idle, start+abort, n==0, start/prog while busy
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5 idle abort busy", bus.busy, 1'b0);
    check("t5 idle abort sw",   Switches, 16'h0020);
    check("t5 idle abort idx",  bus.entry_idx, 4'd1);
    bus.num_entries = 5'd1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t5 start+abort busy", bus.busy, 1'b0);
    go(0);
    check("t5 n0 busy", bus.busy, 1'b0);
    tick();
    check("t5 n0 done", bus.done, 1'b0);
    go(2);
    bus.num_entries = 5'd1;
    bus.start       = 1'b1;
    bus.prog_addr   = 4'd1;
    bus.prog_wdata  = ent(20'd0, 16'h00AA, 2'b00, 16'd0);
    bus.prog_we     = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    wait_done(20, cycles);
    check("t5 busy-start latency", cycles, 8);
    check("t5 table unchanged sw", Switches, 16'h0020);
    check("t5 last idx",           bus.entry_idx, 4'd1);

    // Write-first: start sees entry 0 written in the same cycle
    bus.prog_addr   = 4'd0;
    bus.prog_wdata  = ent(20'd0, 16'h0055, 2'b00, 16'd0);
    bus.prog_we     = 1'b1;
    bus.num_entries = 5'd1;
    bus.start       = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    tick();
    check("t5 write-first sw",   Switches, 16'h0055);
    check("t5 write-first done", bus.done, 1'b1);
    check("t5 write-first busy", bus.busy, 1'b0);

    // num_entries above DEPTH clamps to the full table
    for (int i = 0; i < 16; i++) prog(i, ent(20'd0, 16'h0100 + 16'(i), 2'b00, 16'd0));
    go(20);
    wait_done(40, cycles);
    check("t6 clamp latency", cycles, 16);
    check("t6 clamp idx",     bus.entry_idx, 4'd15);
    check("t6 clamp sw",      Switches, 16'h010F);

    // Asynchronous reset in the middle of a press
    prog(0, ent(20'd3, 16'h0077, 2'b01, 16'd5));
    go(1);
    for (int k = 1; k <= 5; k++) tick();
    check("t7 btn pressed", Buttons, 2'b01);
    check("t7 sw applied",  Switches, 16'h0077);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t7 async sw",   Switches, 16'h0001);
    check("t7 async btn",  Buttons, 2'b00);
    check("t7 async busy", bus.busy, 1'b0);
    check("t7 async idx",  bus.entry_idx, 4'd0);
    #10;
    HRESETn = 1'b1;
    tick();
    check("t7 post reset busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
